// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: default widths,
// source encodings and the CDB broadcast record layout.
package cdb_arbiter_pkg;

    localparam int ROB_POS_W_DEF = 4;
    localparam int DATA_W_DEF    = 32;

    // Source encoding carried on cdb_src
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    // CDB record at the default widths, for consumers of the broadcast
    typedef struct packed {
        logic                     valid;
        logic [ROB_POS_W_DEF-1:0] rob_pos;
        logic [DATA_W_DEF-1:0]    val;
        logic                     src;
    } cdb_rec_t;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO. Push and pop in the same cycle keep the count
// unchanged, also when full (the popped slot is the one being refilled).
// flush_i clears pointers and count and wins over en_i; en_i low freezes all.
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          flush_i,
    input  logic          en_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves this cycle
    assign do_push = en_i && push_i && (!full_o || pop_i);
    assign do_pop  = en_i && pop_i && !empty_o;

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Producer ignored its stall: the result is dropped
    always_ff @(posedge clk) begin
        if (!flush_i && en_i && push_i && full_o && !pop_i) begin
            $error("cdb_fifo overflow: result dropped");
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and LSB result streams onto one registered common data bus.
// Each source is buffered in a cdb_fifo; a source's candidate is its FIFO
// head, or the incoming result when the FIFO is empty (1-cycle latency).
// Arbitration is round-robin by default; defining CDB_LSB_PRIO_EN gives the
// LSB fixed priority. rst and rollback both flush the block.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_POS_W = ROB_POS_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_valid,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    input  logic [DATA_W-1:0]    alu_val,
    output logic                 alu_stall,
    input  logic                 lsb_valid,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos,
    input  logic [DATA_W-1:0]    lsb_val,
    output logic                 lsb_stall,
    output logic                 cdb_valid,
    output logic [ROB_POS_W-1:0] cdb_rob_pos,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 cdb_src
);

    localparam int EW = ROB_POS_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                 valid;
        logic [ROB_POS_W-1:0] rob_pos;
        logic [DATA_W-1:0]    val;
        logic                 src;
    } cdb_t;

    logic          flush;
    logic [EW-1:0] alu_din, lsb_din, alu_head, lsb_head;
    logic [EW-1:0] alu_cand_e, lsb_cand_e;
    logic          alu_empty, lsb_empty, alu_full, lsb_full;
    logic [CW-1:0] alu_count, lsb_count;
    logic          alu_cand, lsb_cand;
    logic          grant_alu, grant_lsb;
    logic          alu_push, alu_pop, lsb_push, lsb_pop;
    cdb_t          cdb_q, cdb_d;

    assign flush   = rst || rollback;
    assign alu_din = {alu_rob_pos, alu_val};
    assign lsb_din = {lsb_rob_pos, lsb_val};

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
        .clk     (clk),
        .flush_i (flush),
        .en_i    (rdy),
        .push_i  (alu_push),
        .pop_i   (alu_pop),
        .din_i   (alu_din),
        .head_o  (alu_head),
        .empty_o (alu_empty),
        .full_o  (alu_full),
        .count_o (alu_count)
    );

    cdb_fifo #(.DEPTH(DEPTH), .W(EW)) u_lsb_fifo (
        .clk     (clk),
        .flush_i (flush),
        .en_i    (rdy),
        .push_i  (lsb_push),
        .pop_i   (lsb_pop),
        .din_i   (lsb_din),
        .head_o  (lsb_head),
        .empty_o (lsb_empty),
        .full_o  (lsb_full),
        .count_o (lsb_count)
    );

    // Candidate per source: queued head first, otherwise the bypassed input
    assign alu_cand   = !alu_empty || alu_valid;
    assign lsb_cand   = !lsb_empty || lsb_valid;
    assign alu_cand_e = alu_empty ? alu_din : alu_head;
    assign lsb_cand_e = lsb_empty ? lsb_din : lsb_head;

`ifdef CDB_LSB_PRIO_EN
    // Fixed priority: the LSB wins every contest
    assign grant_lsb = lsb_cand;
`else
    logic last_grant_q;

    // Remember the last winner so a contest goes to the other source
    always_ff @(posedge clk) begin
        if (flush) begin
            last_grant_q <= SRC_LSB;
        end else if (rdy && (grant_alu || grant_lsb)) begin
            last_grant_q <= grant_lsb ? SRC_LSB : SRC_ALU;
        end
    end

    assign grant_lsb = lsb_cand && (!alu_cand || (last_grant_q == SRC_ALU));
`endif

    assign grant_alu = alu_cand && !grant_lsb;

    // A granted bypass never enters the FIFO; a granted head leaves it
    assign alu_push = alu_valid && !(alu_empty && grant_alu);
    assign alu_pop  = !alu_empty && grant_alu;
    assign lsb_push = lsb_valid && !(lsb_empty && grant_lsb);
    assign lsb_pop  = !lsb_empty && grant_lsb;

    // Next broadcast: load the winner, else drop valid and hold the payload
    always_comb begin
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        if (grant_alu) begin
            cdb_d.valid   = 1'b1;
            cdb_d.rob_pos = alu_cand_e[EW-1 -: ROB_POS_W];
            cdb_d.val     = alu_cand_e[DATA_W-1:0];
            cdb_d.src     = SRC_ALU;
        end else if (grant_lsb) begin
            cdb_d.valid   = 1'b1;
            cdb_d.rob_pos = lsb_cand_e[EW-1 -: ROB_POS_W];
            cdb_d.val     = lsb_cand_e[DATA_W-1:0];
            cdb_d.src     = SRC_LSB;
        end
    end

    // CDB output register; flush wins over rdy
    always_ff @(posedge clk) begin
        if (flush) begin
            cdb_q <= '0;
        end else if (rdy) begin
            cdb_q <= cdb_d;
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_rob_pos = cdb_q.rob_pos;
    assign cdb_val     = cdb_q.val;
    assign cdb_src     = cdb_q.src;

    // One entry of margin for a result already in flight when stall is seen
    assign alu_stall = alu_full || (alu_count >= CW'(DEPTH - 1));
    assign lsb_stall = lsb_full || (lsb_count >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (DEPTH=4, 4-bit tags, 32-bit values).
// Round-robin scenarios run in the default build; the fixed-priority
// scenario runs when CDB_LSB_PRIO_EN is defined.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        alu_valid, lsb_valid;
    logic [3:0]  alu_rob_pos, lsb_rob_pos;
    logic [31:0] alu_val, lsb_val;
    logic        alu_stall, lsb_stall;
    logic        cdb_valid, cdb_src;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_val;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {tag, value} per source, in broadcast order
    logic [35:0] alu_q[$];
    logic [35:0] lsb_q[$];

    cdb_arbiter #(.DEPTH(4), .ROB_POS_W(4), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .alu_valid   (alu_valid),
        .alu_rob_pos (alu_rob_pos),
        .alu_val     (alu_val),
        .alu_stall   (alu_stall),
        .lsb_valid   (lsb_valid),
        .lsb_rob_pos (lsb_rob_pos),
        .lsb_val     (lsb_val),
        .lsb_stall   (lsb_stall),
        .cdb_valid   (cdb_valid),
        .cdb_rob_pos (cdb_rob_pos),
        .cdb_val     (cdb_val),
        .cdb_src     (cdb_src)
    );

    // Clock
    always #5 clk = ~clk;

    // Value encoding: source marker in the top nibble, tag in the low bits
    function automatic logic [31:0] mkval(input logic src, input logic [3:0] tag);
        return (src ? 32'hB000_0000 : 32'hA000_0000) | {28'd0, tag};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_cdb(input string tag, input logic [3:0] rob, input logic src);
        check({tag, "_valid"}, 64'(cdb_valid), 64'd1);
        check({tag, "_pos"},   64'(cdb_rob_pos), 64'(rob));
        check({tag, "_val"},   64'(cdb_val), 64'(mkval(src, rob)));
        check({tag, "_src"},   64'(cdb_src), 64'(src));
    endtask

    // Advance one cycle; outputs are stable #1 after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [3:0] at,
                         input logic lv, input logic [3:0] lt);
        alu_valid   = av;
        alu_rob_pos = at;
        alu_val     = mkval(1'b0, at);
        lsb_valid   = lv;
        lsb_rob_pos = lt;
        lsb_val     = mkval(1'b1, lt);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        rollback = 1'b0;
        idle();
        tick();
        do_reset();

        // Reset state
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_pos",   64'(cdb_rob_pos), 64'd0);
        check("rst_val",   64'(cdb_val), 64'd0);
        check("rst_src",   64'(cdb_src), 64'd0);
        check("rst_astall", 64'(alu_stall), 64'd0);
        check("rst_lstall", 64'(lsb_stall), 64'd0);

        // ALU-only single result: one cycle latency, then valid drops, payload holds
        drive(1'b1, 4'd5, 1'b0, 4'd0);
        alu_val = 32'h1234;
        tick();
        check("alu1_valid", 64'(cdb_valid), 64'd1);
        check("alu1_pos",   64'(cdb_rob_pos), 64'd5);
        check("alu1_val",   64'(cdb_val), 64'h1234);
        check("alu1_src",   64'(cdb_src), 64'd0);
        idle();
        tick();
        check("alu1_drop",  64'(cdb_valid), 64'd0);
        check("alu1_hold",  64'(cdb_rob_pos), 64'd5);

`ifndef CDB_LSB_PRIO_EN
        // Simultaneous after reset: ALU first, then alternation
        do_reset();
        drive(1'b1, 4'd1, 1'b1, 4'd2);
        tick();
        check_cdb("sim_a1", 4'd1, 1'b0);
        drive(1'b1, 4'd3, 1'b1, 4'd4);
        tick();
        check_cdb("sim_l2", 4'd2, 1'b1);
        idle();
        tick();
        check_cdb("sim_a3", 4'd3, 1'b0);
        tick();
        check_cdb("sim_l4", 4'd4, 1'b1);
        tick();
        check("sim_end", 64'(cdb_valid), 64'd0);

        // Backpressure: both valid for 8 cycles, 16 broadcasts alternating A/L
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k < 8) begin
                drive(1'b1, 4'(k), 1'b1, 4'(8 + k));
                alu_q.push_back({4'(k), mkval(1'b0, 4'(k))});
                lsb_q.push_back({4'(8 + k), mkval(1'b1, 4'(8 + k))});
            end else begin
                idle();
            end
            tick();
            check("bp_valid", 64'(cdb_valid), 64'd1);
            check("bp_src",   64'(cdb_src), 64'(k % 2));
            if ((k % 2) == 0) begin
                if (alu_q.size() > 0) check("bp_alu", 64'({cdb_rob_pos, cdb_val}), 64'(alu_q.pop_front()));
            end else begin
                if (lsb_q.size() > 0) check("bp_lsb", 64'({cdb_rob_pos, cdb_val}), 64'(lsb_q.pop_front()));
            end
            if (k == 3) begin
                check("bp3_astall", 64'(alu_stall), 64'd0);
                check("bp3_lstall", 64'(lsb_stall), 64'd0);
            end
            if (k == 4) begin
                check("bp4_astall", 64'(alu_stall), 64'd0);
                check("bp4_lstall", 64'(lsb_stall), 64'd1);
            end
            if (k == 5) begin
                check("bp5_astall", 64'(alu_stall), 64'd1);
                check("bp5_lstall", 64'(lsb_stall), 64'd1);
            end
        end
        tick();
        check("bp_end_valid",  64'(cdb_valid), 64'd0);
        check("bp_end_astall", 64'(alu_stall), 64'd0);
        check("bp_end_lstall", 64'(lsb_stall), 64'd0);

        // Rollback mid-drain: 5 contested cycles leave 3 LSB and 2 ALU queued
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'(1 + k), 1'b1, 4'(9 + k));
            tick();
        end
        idle();
        check("rb_pre_lstall", 64'(lsb_stall), 64'd1);
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        check("rb_valid",  64'(cdb_valid), 64'd0);
        check("rb_pos",    64'(cdb_rob_pos), 64'd0);
        check("rb_astall", 64'(alu_stall), 64'd0);
        check("rb_lstall", 64'(lsb_stall), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rb_quiet", 64'(cdb_valid), 64'd0);
        end

        // rdy low with two ALU entries queued: everything freezes, then drains in order
        do_reset();
        drive(1'b1, 4'd1, 1'b1, 4'd9);
        tick();
        check_cdb("rdy_a1", 4'd1, 1'b0);
        drive(1'b1, 4'd2, 1'b1, 4'd10);
        tick();
        check_cdb("rdy_l9", 4'd9, 1'b1);
        drive(1'b1, 4'd3, 1'b1, 4'd11);
        tick();
        check_cdb("rdy_a2", 4'd2, 1'b0);
        drive(1'b1, 4'd4, 1'b0, 4'd0);
        tick();
        check_cdb("rdy_l10", 4'd10, 1'b1);
        rdy = 1'b0;
        drive(1'b1, 4'd7, 1'b1, 4'd15);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_cdb("rdy_frozen", 4'd10, 1'b1);
            check("rdy_frz_astall", 64'(alu_stall), 64'd0);
        end
        rdy = 1'b1;
        idle();
        tick();
        check_cdb("rdy_a3", 4'd3, 1'b0);
        tick();
        check_cdb("rdy_l11", 4'd11, 1'b1);
        tick();
        check_cdb("rdy_a4", 4'd4, 1'b0);
        tick();
        check("rdy_end", 64'(cdb_valid), 64'd0);
`else
        // Fixed LSB priority: three LSB broadcasts, then ALU drains in order
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'(1 + k), 1'b1, 4'(9 + k));
            tick();
            check_cdb("prio_lsb", 4'(9 + k), 1'b1);
        end
        idle();
        check("prio_astall", 64'(alu_stall), 64'd1);
        check("prio_lstall", 64'(lsb_stall), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_cdb("prio_alu", 4'(1 + k), 1'b0);
        end
        tick();
        check("prio_end", 64'(cdb_valid), 64'd0);
        check("prio_end_astall", 64'(alu_stall), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Merges the ALU and load/store-buffer result streams onto one registered common data bus (CDB).
- The single CDB is then broadcast to the reservation station, LSB and ROB in place of separate per-unit result buses.
- Each source has a small result FIFO, so a source can produce while the other holds the bus.
- Round-robin arbitration decides which source drives the CDB; rollback flushes the block.

Parameters:
- DEPTH, 4, entries per source FIFO (power of two, >=2)
- ROB_POS_W, 4, width of the ROB position tag
- DATA_W, 32, width of the result value

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- rollback  in  1  branch-mispredict flush; same effect as rst on this block
- alu_valid  in  1  ALU result present this cycle
- alu_rob_pos  in  ROB_POS_W  ROB tag of ALU result
- alu_val  in  DATA_W  ALU result value
- alu_stall  out  1  ALU must not issue a new op (its FIFO is almost full)
- lsb_valid  in  1  LSB result present this cycle
- lsb_rob_pos  in  ROB_POS_W  ROB tag of LSB result
- lsb_val  in  DATA_W  LSB result value
- lsb_stall  out  1  LSB must not produce a new result
- cdb_valid  out  1  broadcast valid (registered)
- cdb_rob_pos  out  ROB_POS_W  broadcast tag (registered)
- cdb_val  out  DATA_W  broadcast value (registered)
- cdb_src  out  1  0 = ALU, 1 = LSB (registered)

Behaviour:
- Reset / rollback (sync, priority over rdy):
  - FIFO counts and pointers = 0.
  - cdb_valid = 0, cdb_rob_pos = 0, cdb_val = 0, cdb_src = 0.
  - last_grant = 1, so the ALU wins the first contest.
  - Inputs present in that cycle are discarded.
- rdy low: all registers hold and inputs are ignored. Producers are frozen by the same rdy.
- Candidate per source: the FIFO head if the FIFO is non-empty, otherwise the incoming result if valid. This gives minimum latency of 1 cycle (input at cycle t, on CDB at t+1).
- Grant rules:
  - One candidate valid: grant it.
  - Both valid: grant the source != last_grant.
  - last_grant updates on every grant.
- Output register:
  - On a grant, load tag/value/src and set cdb_valid = 1.
  - Otherwise cdb_valid = 0; tag/value/src hold their previous values.
- FIFO update per source each cycle:
  - Push the incoming result unless it was granted directly (empty FIFO and granted).
  - Pop the head if the head was granted.
  - Push and pop in the same cycle leaves the count unchanged, including when full.
  - Pointers wrap modulo DEPTH. The count is clog2(DEPTH)+1 bits.
- Stall: src_stall = (count >= DEPTH-1), combinational from registered count. The one-cycle margin covers a result already in flight when the stall is sampled.
- Overflow (push when full without pop) is a protocol violation. Under simulation it is flagged by $error; the data is dropped.
- Order is preserved within a source. No ordering is guaranteed across sources.
- A result and the CDB broadcast of the same tag never coincide inside this block: no forwarding is needed.

Optional Feature:
- CDB_LSB_PRIO_EN:
  - Defined: fixed priority, LSB always wins contests and last_grant is unused. This minimises load-use latency; the ALU can starve only while the LSB is continuously valid.
  - Undefined: round-robin as above.

Decomposition:
- Shared package/header holds:
  - ROB_POS_W and DATA_W defaults
  - SRC_ALU = 1'b0, SRC_LSB = 1'b1
  - CDB record layout (valid, rob_pos, val, src)
- Sub-module cdb_fifo (DEPTH, width = ROB_POS_W+DATA_W), instantiated twice.
  - Ports: push, pop, din, head, empty, full, count; flush on rst|rollback.
- Arbitration and output register live in the top level.

Test Plan:
- ALU-only single result: alu_valid=1, tag 5, val 0x1234 at cycle t -> cdb_valid=1, rob_pos 5, val 0x1234, src 0 at t+1; cdb_valid=0 at t+2.
- Simultaneous results after reset: ALU tag 1, LSB tag 2 at t -> CDB shows tag 1 (ALU) at t+1, tag 2 (LSB) at t+2. Repeat contest -> LSB wins first (alternation).
- Backpressure: ALU and LSB both valid every cycle for 8 cycles with DEPTH=4 -> alu_stall/lsb_stall assert once count reaches 3; no result lost; per-source order preserved across 16 broadcasts.
- Rollback mid-drain: 3 LSB entries queued, rollback pulsed -> next cycle cdb_valid=0, both counts 0, stalls low; queued tags never appear on the CDB.
- rdy low for 3 cycles with 2 queued ALU entries -> CDB and counts frozen; on rdy return the entries drain in order, one per cycle.
- With CDB_LSB_PRIO_EN: both valid for 3 cycles -> three LSB broadcasts before any ALU broadcast; ALU entries then drain in order.
